// File: rtl/multi_debouncer.sv
// multi_debouncer: independent per-channel debouncers with input synchronisers.
// Each channel synchronises its raw input, then runs a 4-state FSM that accepts
// a new level only after it has been stable for N+1 consecutive samples, where
// N = max(rise_time, 1) for 0->1 changes and N = max(fall_time, 1) for 1->0.
// The threshold is latched when a check window opens.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   noisy_in   - raw asynchronous inputs, one bit per channel
//   en         - global enable; when low, open windows abort and stable states hold
//   rise_time  - settle cycles for accepting a 0->1 change
//   fall_time  - settle cycles for accepting a 1->0 change
//   db_out     - debounced level (registered)
//   rise_pulse - one-cycle strobe on db_out 0->1
//   fall_pulse - one-cycle strobe on db_out 1->0
//   checking   - channel currently has a check window open
`timescale 1ns/1ps
module multi_debouncer #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy_in,
  input  logic                en,
  input  logic [CNT_W-1:0]    rise_time,
  input  logic [CNT_W-1:0]    fall_time,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] checking
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  // Effective thresholds: a programmed 0 behaves as 1.
  logic [CNT_W-1:0] rise_n;
  logic [CNT_W-1:0] fall_n;

  assign rise_n = (rise_time == '0) ? CNT_W'(1) : rise_time;
  assign fall_n = (fall_time == '0) ? CNT_W'(1) : fall_time;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       thr_q;
    logic [CNT_W-1:0]       thr_d;
    logic                   db_d;
    logic                   chk_d;
    logic                   db_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   chk_q;

    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state, counter and threshold-latch logic.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      case (state_q)
        IDLE: begin
          if (en && sync) begin
            state_d = CHECK_HIGH;
            cnt_d   = '0;
            thr_d   = rise_n;
          end
        end
        CHECK_HIGH: begin
          if (!en || !sync) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == thr_q - CNT_W'(1)) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (en && !sync) begin
            state_d = CHECK_LOW;
            cnt_d   = '0;
            thr_d   = fall_n;
          end
        end
        CHECK_LOW: begin
          if (!en || sync) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == thr_q - CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decodes of the next state so they update on the same edge as the state.
    assign db_d  = (state_d == HIGH) || (state_d == CHECK_LOW);
    assign chk_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);

    // Synchroniser, state and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        thr_q   <= CNT_W'(1);
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        chk_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy_in[i]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        thr_q   <= thr_d;
        db_q    <= db_d;
        rise_q  <= db_d & ~db_q;
        fall_q  <= ~db_d & db_q;
        chk_q   <= chk_d;
      end
    end

    assign db_out[i]     = db_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign checking[i]   = chk_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed-vector bench for multi_debouncer.
// Main instance: 4 channels, 16-bit counter, 2 sync stages.
// Second instance: 1 channel, 4-bit counter, for the maximum-threshold case.
`timescale 1ns/1ps
module tb_multi_debouncer;

  logic        clk;
  logic        rst;
  logic [3:0]  noisy_in;
  logic        en;
  logic [15:0] rise_time;
  logic [15:0] fall_time;
  logic [3:0]  db_out;
  logic [3:0]  rise_pulse;
  logic [3:0]  fall_pulse;
  logic [3:0]  checking;

  logic        noisy4;
  logic [3:0]  rise4;
  logic [3:0]  fall4;
  logic        db4;
  logic        rise_p4;
  logic        fall_p4;
  logic        chk4;

  int n_checks = 0;
  int n_pass   = 0;

  int rise_cnt [4];
  int fall_cnt [4];
  int chk_cyc  [4];
  int both_cnt;

  multi_debouncer #(.CHANNELS(4), .CNT_W(16), .SYNC_STAGES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .noisy_in  (noisy_in),
    .en        (en),
    .rise_time (rise_time),
    .fall_time (fall_time),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .checking  (checking)
  );

  multi_debouncer #(.CHANNELS(1), .CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .noisy_in  (noisy4),
    .en        (en),
    .rise_time (rise4),
    .fall_time (fall4),
    .db_out    (db4),
    .rise_pulse(rise_p4),
    .fall_pulse(fall_p4),
    .checking  (chk4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      chk_cyc[i]  = 0;
    end
    both_cnt = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = rise_cnt[i] + 32'(rise_pulse[i]);
      fall_cnt[i] = fall_cnt[i] + 32'(fall_pulse[i]);
      chk_cyc[i]  = chk_cyc[i] + 32'(checking[i]);
    end
    if ((rise_pulse & fall_pulse) != 4'b0000) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Count edges (first edge after the call is 1) until db_out&mask == lvl&mask.
  // Optionally rewrites noisy_in/rise_time at the negedge after edge act_at.
  task automatic wait_db(input logic [3:0] mask, input logic [3:0] lvl, input int budget,
                         input int act_at, input logic [3:0] act_noisy,
                         input logic [15:0] act_rise, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if ((db_out & mask) == (lvl & mask)) begin
        lat = k;
        break;
      end
      if (k == act_at) begin
        @(negedge clk);
        noisy_in  = act_noisy;
        rise_time = act_rise;
      end
    end
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    noisy_in = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lat2;
    int snap;
    int snap_chk;

    rst       = 1'b1;
    en        = 1'b1;
    noisy_in  = 4'hF;
    rise_time = 16'd4;
    fall_time = 16'd4;
    noisy4    = 1'b0;
    rise4     = 4'd15;
    fall4     = 4'd15;

    // Reset held 3 cycles with all inputs high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_db", 32'(db_out), 0);
    check("rst_rise", 32'(rise_pulse), 0);
    check("rst_fall", 32'(fall_pulse), 0);
    check("rst_chk", 32'(checking), 0);

    // Release: all channels accept after 2+4+1 edges.
    @(negedge clk);
    rst = 1'b0;
    wait_db(4'hF, 4'hF, 30, 0, noisy_in, rise_time, lat);
    check("rst_rel_lat", 32'(lat), 7);
    check("rst_rel_rise", 32'(rise_pulse), 32'h0000_000F);
    @(posedge clk); #1;
    check("rst_rel_rise_off", 32'(rise_pulse), 0);
    check("rst_rel_db", 32'(db_out), 32'h0000_000F);

    // All fall with fall_time=4.
    drive(4'h0);
    wait_db(4'hF, 4'h0, 30, 0, noisy_in, rise_time, lat);
    check("fall_all_lat", 32'(lat), 7);
    check("fall_all_pulse", 32'(fall_pulse), 32'h0000_000F);
    repeat (3) @(posedge clk);

    // Glitch: 4-cycle high pulse on ch0 with rise_time=5 is rejected.
    rise_time = 16'd5;
    snap     = rise_cnt[0];
    snap_chk = chk_cyc[0];
    drive(4'b0001);
    repeat (4) @(negedge clk);
    noisy_in = 4'b0000;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_db", 32'(db_out[0]), 0);
    check("glitch_no_rise", 32'(rise_cnt[0] - snap), 0);
    check("glitch_chk_seen", 32'(chk_cyc[0] != snap_chk), 1);
    check("glitch_chk_idle", 32'(checking[0]), 0);

    // 6-cycle pulse is accepted after 8 edges, then falls fall_time+3 edges after the drop.
    snap = fall_cnt[0];
    drive(4'b0001);
    wait_db(4'b0001, 4'b0001, 30, 6, 4'b0000, 16'd5, lat);
    check("pulse6_lat", 32'(lat), 8);
    check("pulse6_rise", 32'(rise_pulse), 32'h0000_0001);
    wait_db(4'b0001, 4'b0000, 30, 0, noisy_in, rise_time, lat2);
    check("pulse6_fall_lat", 32'(lat2 + 2), 7);
    check("pulse6_fall_pulse", 32'(fall_pulse), 32'h0000_0001);
    repeat (2) @(posedge clk);
    check("pulse6_fall_cnt", 32'(fall_cnt[0] - snap), 1);

    // Asymmetric times on ch1; rise_time rewritten to 20 mid-window.
    rise_time = 16'd2;
    fall_time = 16'd10;
    drive(4'b0010);
    wait_db(4'b0010, 4'b0010, 30, 3, 4'b0010, 16'd20, lat);
    check("asym_rise_lat", 32'(lat), 5);
    drive(4'b0000);
    wait_db(4'b0010, 4'b0000, 30, 0, noisy_in, rise_time, lat);
    check("asym_fall_lat", 32'(lat), 13);
    drive(4'b0010);
    wait_db(4'b0010, 4'b0010, 40, 0, noisy_in, rise_time, lat);
    check("asym_new_rise_lat", 32'(lat), 23);
    drive(4'b0000);
    wait_db(4'b0010, 4'b0000, 30, 0, noisy_in, rise_time, lat);
    check("asym_fall2_lat", 32'(lat), 13);

    // rise_time=0 behaves as 1 on ch2 (ch2 then stays HIGH).
    rise_time = 16'd0;
    drive(4'b0100);
    wait_db(4'b0100, 4'b0100, 30, 0, noisy_in, rise_time, lat);
    check("zero_thr_lat", 32'(lat), 4);

    // en drop during ch1 CHECK_HIGH while ch2 is HIGH.
    rise_time = 16'd10;
    snap = rise_cnt[1];
    drive(4'b0110);
    repeat (4) @(posedge clk);
    #1;
    check("en_chk_before", 32'(checking[1]), 1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check("en_chk_abort", 32'(checking[1]), 0);
    repeat (12) @(posedge clk);
    #1;
    check("en_ch1_db", 32'(db_out[1]), 0);
    check("en_ch2_db", 32'(db_out[2]), 1);
    check("en_ch1_no_rise", 32'(rise_cnt[1] - snap), 0);
    drive(4'b0100);
    repeat (4) @(negedge clk);
    en = 1'b1;

    // Bring ch3 HIGH, then rise ch0 and fall ch3 on the same edge.
    rise_time = 16'd3;
    fall_time = 16'd3;
    drive(4'b1100);
    wait_db(4'b1000, 4'b1000, 30, 0, noisy_in, rise_time, lat);
    check("ch3_rise_lat", 32'(lat), 6);
    repeat (2) @(posedge clk);
    drive(4'b0101);
    wait_db(4'b1001, 4'b0001, 30, 0, noisy_in, rise_time, lat);
    check("simul_lat", 32'(lat), 6);
    check("simul_rise", 32'(rise_pulse), 32'h0000_0001);
    check("simul_fall", 32'(fall_pulse), 32'h0000_0008);
    check("simul_db", 32'(db_out), 32'h0000_0005);

    // Reset during ch0 CHECK_LOW: no fall pulse ever appears.
    fall_time = 16'd10;
    drive(4'b0100);
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_chk", 32'(checking[0]), 1);
    snap = fall_cnt[0];
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_db", 32'(db_out[0]), 0);
    check("rstmid_fall", 32'(fall_pulse), 0);
    check("rstmid_chk_clr", 32'(checking), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_no_fall", 32'(fall_cnt[0] - snap), 0);
    check("rstmid_db_after", 32'(db_out[0]), 0);

    // CNT_W=4 with rise_time=15: latency 18, no wrap afterwards.
    @(negedge clk);
    noisy4 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (db4) begin
        lat = k;
        break;
      end
    end
    check("cnt4_lat", 32'(lat), 18);
    check("cnt4_rise", 32'(rise_p4), 1);
    repeat (20) @(posedge clk);
    #1;
    check("cnt4_hold_db", 32'(db4), 1);
    check("cnt4_hold_chk", 32'(chk4), 0);

    check("never_both_pulses", 32'(both_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
